// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared data cache state encoding and address slicing helpers
package dcache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_MISS        = 3'd1,
        ST_WRITEBACK   = 3'd2,
        ST_REFILL      = 3'd3,
        ST_REFILL_DONE = 3'd4
    } state_e;

    // Tag field: everything above index and byte offset.
    function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int off_w, input int idx_w);
        return addr >> (off_w + idx_w);
    endfunction

    // Set index: the idx_w bits directly above the byte offset.
    function automatic logic [63:0] addr_index(input logic [63:0] addr, input int off_w, input int idx_w);
        return (addr >> off_w) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    // 32-bit word within the line; byte-within-word bits are dropped.
    function automatic logic [63:0] addr_word(input logic [63:0] addr, input int off_w);
        return (addr >> 2) & ((64'd1 << (off_w - 2)) - 64'd1);
    endfunction

endpackage

// File: rtl/dcache_way_data.sv
// rtl/dcache_way_data.sv - one way of line storage, synchronous write, combinational read
module dcache_way_data #(
    parameter int LINE_W = 256,
    parameter int SETS   = 32,
    parameter int IDX_W  = $clog2(SETS)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [LINE_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] line_q [SETS];

    // Line storage is deliberately not reset; valid bits in the top gate its use.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            line_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = line_q[raddr_i];

endmodule

// File: rtl/dcache_2way_top.sv
// rtl/dcache_2way_top.sv - 2-way set-associative write-back write-allocate L1 data cache
module dcache_2way_top
    import dcache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 32,
    parameter int OFF_W  = $clog2(LINE_W/8),
    parameter int IDX_W  = $clog2(SETS),
    parameter int TAG_W  = ADDR_W - IDX_W - OFF_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [31:0]       p1_data_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o
);

    localparam int WORDS  = LINE_W / 32;
    localparam int WORD_W = OFF_W - 2;

    state_e state_q, state_d;
    logic   victim_q, victim_d;
    logic   mem_enable_q, mem_enable_d;
    logic   mem_write_q, mem_write_d;

    logic [1:0][SETS-1:0]            valid_q, valid_d;
    logic [1:0][SETS-1:0]            dirty_q, dirty_d;
    logic [SETS-1:0]                 lru_q, lru_d;
    logic [1:0][SETS-1:0][TAG_W-1:0] tag_q, tag_d;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WORD_W-1:0] req_word;
    logic              req;
    logic              hit0, hit1, hit, hit_way;
    logic              victim_sel;

    logic [1:0][LINE_W-1:0] way_line;
    logic [1:0]             way_we;
    logic [LINE_W-1:0]      way_wdata;
    logic [LINE_W-1:0]      hit_line, merged_line, victim_line;
    logic [31:0]            hit_word;

    assign req_tag  = TAG_W'(addr_tag(64'(p1_addr_i), OFF_W, IDX_W));
    assign req_idx  = IDX_W'(addr_index(64'(p1_addr_i), OFF_W, IDX_W));
    assign req_word = WORD_W'(addr_word(64'(p1_addr_i), OFF_W));
    assign req      = p1_MemRead_i | p1_MemWrite_i;

    assign hit0    = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
    assign hit1    = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
    assign hit     = hit0 | hit1;
    assign hit_way = hit1;

    // Fill an empty way first; only evict by LRU when both ways are occupied.
    assign victim_sel = !valid_q[0][req_idx] ? 1'b0 :
                        !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];

    assign hit_line    = hit_way  ? way_line[1] : way_line[0];
    assign victim_line = victim_q ? way_line[1] : way_line[0];

    genvar gw;
    generate
        for (gw = 0; gw < 2; gw++) begin : g_way
            dcache_way_data #(
                .LINE_W (LINE_W),
                .SETS   (SETS),
                .IDX_W  (IDX_W)
            ) u_way (
                .clk_i   (clk_i),
                .we_i    (way_we[gw]),
                .waddr_i (req_idx),
                .wdata_i (way_wdata),
                .raddr_i (req_idx),
                .rdata_o (way_line[gw])
            );
        end
    endgenerate

    // Pick the addressed word for loads and build the store-merged line.
    always_comb begin
        hit_word    = '0;
        merged_line = hit_line;
        for (int i = 0; i < WORDS; i++) begin
            if (req_word == WORD_W'(i)) begin
                hit_word                = hit_line[i*32 +: 32];
                merged_line[i*32 +: 32] = p1_data_i;
            end
        end
    end

    assign p1_data_o    = hit ? hit_word : 32'd0;
    assign p1_stall_o   = (req & ~hit) | (state_q != ST_IDLE);
    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_data_o   = victim_line;
    assign mem_addr_o   = (state_q == ST_WRITEBACK) ?
                          {tag_q[victim_q][req_idx], req_idx, {OFF_W{1'b0}}} :
                          {req_tag, req_idx, {OFF_W{1'b0}}};

    // Miss handling sequence plus hit-time LRU, dirty and store-merge updates.
    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        lru_d        = lru_q;
        tag_d        = tag_q;
        way_we       = 2'b00;
        way_wdata    = merged_line;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (hit) begin
                        lru_d[req_idx] = ~hit_way;
                        if (p1_MemWrite_i) begin
                            way_we[hit_way]           = 1'b1;
                            dirty_d[hit_way][req_idx] = 1'b1;
                        end
                    end else begin
                        victim_d = victim_sel;
                        state_d  = ST_MISS;
                    end
                end
            end
            ST_MISS: begin
                mem_enable_d = 1'b1;
                if (valid_q[victim_q][req_idx] && dirty_q[victim_q][req_idx]) begin
                    mem_write_d = 1'b1;
                    state_d     = ST_WRITEBACK;
                end else begin
                    state_d = ST_REFILL;
                end
            end
            ST_WRITEBACK: begin
                if (mem_ack_i) begin
                    mem_write_d = 1'b0;
                    state_d     = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (mem_ack_i) begin
                    way_we[victim_q]           = 1'b1;
                    way_wdata                  = mem_data_i;
                    tag_d[victim_q][req_idx]   = req_tag;
                    valid_d[victim_q][req_idx] = 1'b1;
                    dirty_d[victim_q][req_idx] = 1'b0;
                    mem_enable_d               = 1'b0;
                    state_d                    = ST_REFILL_DONE;
                end
            end
            ST_REFILL_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and line metadata registers; reset aborts any miss in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            victim_q     <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            valid_q      <= '0;
            dirty_q      <= '0;
            lru_q        <= '0;
            tag_q        <= '0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            lru_q        <= lru_d;
            tag_q        <= tag_d;
        end
    end

endmodule

// File: tb/tb_dcache_2way_top.sv
// tb/tb_dcache_2way_top.sv - self-checking bench for dcache_2way_top
module tb_dcache_2way_top;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int SETS   = 32;
    localparam int IDX_W  = 5;
    localparam int TAG_W  = 22;
    localparam int WORDS  = 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_data_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [31:0]       p1_data_i;
    logic [ADDR_W-1:0] p1_addr_i;
    logic              p1_MemRead_i;
    logic              p1_MemWrite_i;
    logic [31:0]       p1_data_o;
    logic              p1_stall_o;

    always #5 clk_i = ~clk_i;

    dcache_2way_top dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .mem_data_o    (mem_data_o),
        .mem_addr_o    (mem_addr_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .p1_data_i     (p1_data_i),
        .p1_addr_i     (p1_addr_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o)
    );

    int errors = 0;
    int checks = 0;
    int mem_lat = 1;
    int rsp_cnt;

    logic [LINE_W-1:0] mem_store [logic [31:0]];
    logic [31:0]       wb_addr_q [$];
    logic [LINE_W-1:0] wb_data_q [$];
    logic [31:0]       rf_addr_q [$];

    // Reference cache: two ways per set, lines held as arrays of words.
    logic              m_valid [2][SETS];
    logic              m_dirty [2][SETS];
    logic [TAG_W-1:0]  m_tag   [2][SETS];
    logic [31:0]       m_word  [2][SETS][WORDS];
    logic              m_lru   [SETS];

    function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] a);
        logic [LINE_W-1:0] l;
        if (mem_store.exists(a)) return mem_store[a];
        for (int i = 0; i < WORDS; i++) l[i*32 +: 32] = (a + 32'(i*4)) ^ 32'h5A5A_0000;
        return l;
    endfunction

    function automatic void model_reset();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < SETS; s++) begin
                m_valid[w][s] = 1'b0;
                m_dirty[w][s] = 1'b0;
            end
        for (int s = 0; s < SETS; s++) m_lru[s] = 1'b0;
    endfunction

    // Memory responder: acks after mem_lat cycles of enable and logs every transfer.
    initial begin
        rsp_cnt    = 0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            mem_ack_i = 1'b0;
            if (rst_i === 1'b1 && mem_enable_o === 1'b1) begin
                rsp_cnt++;
                if (rsp_cnt >= mem_lat) begin
                    rsp_cnt = 0;
                    if (mem_write_o) begin
                        wb_addr_q.push_back(mem_addr_o);
                        wb_data_q.push_back(mem_data_o);
                        mem_store[mem_addr_o] = mem_data_o;
                    end else begin
                        rf_addr_q.push_back(mem_addr_o);
                        mem_data_i = mem_line(mem_addr_o);
                    end
                    mem_ack_i = 1'b1;
                end
            end else begin
                rsp_cnt = 0;
            end
        end
    end

    // One CPU access, starting just after a rising edge; checked against the model.
    task automatic cpu_access(input logic [31:0] addr, input logic we, input logic [31:0] wdata, input string name);
        logic [IDX_W-1:0]  ix;
        logic [TAG_W-1:0]  tg;
        int                wd, way, cycles, exp_cycles;
        bit                hit, exp_wb;
        logic [31:0]       exp_wb_addr, exp_rf_addr, exp_rdata, got_rdata;
        logic [LINE_W-1:0] exp_wb_data, fill;
        ix = addr[9:5];
        tg = addr[31:10];
        wd = int'(addr[4:2]);
        hit = 0; way = 0; exp_wb = 0; exp_cycles = 0;
        exp_wb_addr = '0; exp_wb_data = '0;
        for (int w = 0; w < 2; w++)
            if (m_valid[w][ix] && m_tag[w][ix] == tg) begin hit = 1; way = w; end
        exp_rf_addr = {tg, ix, 5'b0};
        if (!hit) begin
            if (!m_valid[0][ix]) way = 0;
            else if (!m_valid[1][ix]) way = 1;
            else way = int'(m_lru[ix]);
            if (m_valid[way][ix] && m_dirty[way][ix]) begin
                exp_wb      = 1;
                exp_wb_addr = {m_tag[way][ix], ix, 5'b0};
                for (int i = 0; i < WORDS; i++) exp_wb_data[i*32 +: 32] = m_word[way][ix][i];
            end
            exp_cycles = 3 + mem_lat + (exp_wb ? mem_lat : 0);
            fill = mem_line(exp_rf_addr);
            m_valid[way][ix] = 1'b1;
            m_dirty[way][ix] = 1'b0;
            m_tag[way][ix]   = tg;
            for (int i = 0; i < WORDS; i++) m_word[way][ix][i] = fill[i*32 +: 32];
        end
        exp_rdata = m_word[way][ix][wd];
        m_lru[ix] = (way == 0);
        if (we) begin
            m_word[way][ix][wd] = wdata;
            m_dirty[way][ix]    = 1'b1;
        end

        wb_addr_q.delete(); wb_data_q.delete(); rf_addr_q.delete();
        p1_addr_i     = addr;
        p1_data_i     = wdata;
        p1_MemWrite_i = we;
        p1_MemRead_i  = we ? 1'($urandom_range(0, 1)) : 1'b1;
        cycles = 0;
        @(negedge clk_i);
        while (p1_stall_o !== 1'b0 && cycles < 100) begin
            cycles++;
            @(negedge clk_i);
        end
        got_rdata = p1_data_o;
        @(posedge clk_i);
        #1;
        p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;

        checks++;
        if (cycles !== exp_cycles) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", name, cycles, exp_cycles);
        end
        if (!we) begin
            checks++;
            if (got_rdata !== exp_rdata) begin
                errors++;
                $display("FAIL %s load_data: got %h expected %h", name, got_rdata, exp_rdata);
            end
        end
        checks++;
        if (wb_addr_q.size() != (exp_wb ? 1 : 0)) begin
            errors++;
            $display("FAIL %s writeback_count: got %0d expected %0d", name, wb_addr_q.size(), exp_wb);
        end else if (exp_wb) begin
            checks++;
            if (wb_addr_q[0] !== exp_wb_addr || wb_data_q[0] !== exp_wb_data) begin
                errors++;
                $display("FAIL %s writeback: got %h/%h expected %h/%h", name, wb_addr_q[0], wb_data_q[0], exp_wb_addr, exp_wb_data);
            end
        end
        checks++;
        if (rf_addr_q.size() != (hit ? 0 : 1)) begin
            errors++;
            $display("FAIL %s refill_count: got %0d expected %0d", name, rf_addr_q.size(), !hit);
        end else if (!hit) begin
            checks++;
            if (rf_addr_q[0] !== exp_rf_addr) begin
                errors++;
                $display("FAIL %s refill_addr: got %h expected %h", name, rf_addr_q[0], exp_rf_addr);
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        p1_addr_i = 32'h40; p1_data_i = '0; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
        model_reset();
        #23;
        checks++;
        if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem_ctrl: got en=%b wr=%b expected 0/0", mem_enable_o, mem_write_o);
        end
        checks++;
        if (p1_stall_o !== 1'b0 || p1_data_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_idle_outputs: got stall=%b data=%h expected 0/0", p1_stall_o, p1_data_o);
        end
        p1_MemRead_i = 1'b1;
        #1;
        checks++;
        if (p1_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_read_stall: got %b expected 1", p1_stall_o);
        end
        p1_MemRead_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_directed();
        mem_lat = 2;
        cpu_access(32'h0000_0040, 1'b0, 32'h0, "read_miss_0x40");
        cpu_access(32'h0000_0044, 1'b1, 32'hDEAD_BEEF, "write_hit_0x44");
        cpu_access(32'h0000_0044, 1'b0, 32'h0, "read_0x44");
        cpu_access(32'h0000_0040, 1'b0, 32'h0, "read_0x40_unchanged");
        mem_lat = 3;
        cpu_access(32'h0000_0440, 1'b0, 32'h0, "fill_way1_0x440");
        cpu_access(32'h0000_0040, 1'b0, 32'h0, "hit_0x40");
        cpu_access(32'h0000_0440, 1'b0, 32'h0, "hit_0x440");
        cpu_access(32'h0000_0840, 1'b0, 32'h0, "evict_dirty_0x40");
        checks++;
        if (wb_data_q.size() != 1 || wb_data_q[0][63:32] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL evict_word1: got %0d writebacks, expected word1 DEADBEEF", wb_data_q.size());
        end
        mem_lat = 1;
        cpu_access(32'h0000_0C48, 1'b1, 32'h1234_5678, "write_miss_0xC48");
        cpu_access(32'h0000_0C48, 1'b0, 32'h0, "read_0xC48");
        cpu_access(32'h0000_0C40, 1'b0, 32'h0, "read_0xC40");
        cpu_access(32'h0000_1040, 1'b0, 32'h0, "fill_0x1040");
        cpu_access(32'h0000_1440, 1'b0, 32'h0, "evict_dirty_0xC40");
    endtask

    task automatic test_reset_mid_miss();
        int n;
        mem_lat = 2;
        cpu_access(32'h0000_0040, 1'b0, 32'h0, "pre_reset_0x40");
        mem_lat = 8;
        p1_addr_i = 32'h0000_2040; p1_MemRead_i = 1'b1; p1_MemWrite_i = 1'b0;
        n = 0;
        while (mem_enable_o !== 1'b1 && n < 20) begin @(negedge clk_i); n++; end
        checks++;
        if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_refill_start: got en=%b wr=%b expected 1/0", mem_enable_o, mem_write_o);
        end
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checks++;
        if (mem_enable_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_enable_drop: got %b expected 0", mem_enable_o);
        end
        p1_addr_i = 32'h0000_0040;
        #1;
        checks++;
        if (p1_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_invalidate: got stall=%b expected 1", p1_stall_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        p1_MemRead_i = 1'b0;
        model_reset();
        @(posedge clk_i);
        #1;
        mem_lat = 2;
        cpu_access(32'h0000_0040, 1'b0, 32'h0, "post_reset_0x40");
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          tsel, ssel;
        for (int k = 0; k < 250; k++) begin
            tsel = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0: ssel = 0;
                1: ssel = 1;
                2: ssel = 2;
                default: ssel = 31;
            endcase
            a = (32'(tsel) << 10) | (32'(ssel) << 5) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            mem_lat = $urandom_range(1, 4);
            cpu_access(a, 1'($urandom_range(0, 1)), $urandom, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_miss();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
